sys_ctrl_regs: RTL and testbench

- Parametrised successor to the fixed-ID system control block; sits on the same IOC-addressed SPI command bus (i_ioc / i_cs / i_fetch_cmd / i_load_cmd).
- Adds to the read-only identity registers:
  - a writable control register with a self-timed soft-reset pulse generator;
  - a status register with a sticky access-error flag;
  - a parametrised bank of R/W scratch registers for host bus checks.
- Optional heartbeat/uptime counter.

---
 rtl/sys_ctrl_regs.sv | 239 +++++++++++++++++++++++
 tb/tb_sys_ctrl_regs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_regs.sv
// sys_ctrl_regs: system control/identity register block on the IOC command bus.
// Optional heartbeat/uptime counter: define SYS_CTRL_HEARTBEAT_EN to build it.
module sys_ctrl_regs #(
    parameter int          DATA_W          = 8,
    parameter int          IOC_W           = 5,
    parameter int          N_SCRATCH       = 4,
    parameter logic [7:0]  MODULE_VERSION  = 8'h02,
    parameter logic [7:0]  SYSTEM_VERSION  = 8'h01,
    parameter logic [7:0]  MANU_ID         = 8'h01,
    parameter int          SOFT_RST_CYCLES = 16,
    parameter int          HB_DIV_W        = 24
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic [IOC_W-1:0]  i_ioc,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    input  logic              i_cs,
    input  logic              i_fetch_cmd,
    input  logic              i_load_cmd,
    output logic              o_soft_rst,
    output logic [DATA_W-2:0] o_ctrl,
    output logic              o_heartbeat
);

    localparam int CNT_W = $clog2(SOFT_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SOFT_RST_CYCLES);
    localparam logic [IOC_W:0] SCR_LO = (IOC_W+1)'(8);
    localparam logic [IOC_W:0] SCR_HI = (IOC_W+1)'(8 + N_SCRATCH);

    // Reject parameter sets the register map cannot honour.
    if (DATA_W < 4) begin : g_bad_dw
        $error("DATA_W must be >= 4");
    end
    if (N_SCRATCH < 1 || N_SCRATCH > (2**IOC_W - 8)) begin : g_bad_ns
        $error("N_SCRATCH out of range");
    end
    if (SOFT_RST_CYCLES < 1) begin : g_bad_src
        $error("SOFT_RST_CYCLES must be >= 1");
    end
    if (HB_DIV_W <= DATA_W) begin : g_bad_hb
        $error("HB_DIV_W must exceed DATA_W");
    end

    typedef enum logic {
        S_IDLE,
        S_PULSE
    } srst_state_t;

    srst_state_t      state_q;
    srst_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-2:0] ctrl_q;
    logic              err_q;
    logic              err_d;
    logic [DATA_W-1:0] scratch_q [N_SCRATCH];

    logic [IOC_W:0]    ioc_x;
    logic [IOC_W-1:0]  scr_idx;
    logic              is_mv;
    logic              is_sv;
    logic              is_mi;
    logic              is_ctrl;
    logic              is_stat;
    logic              is_up;
    logic              is_scr;
    logic              rd_hit;
    logic              wr_hit;

    logic              fetch_go;
    logic              load_go;
    logic              wr_ctrl;
    logic              wr_scr;
    logic              trig;
    logic              err_clr;
    logic              err_set;
    logic              busy;

    logic [DATA_W-1:0] scr_rd;
    logic [DATA_W-1:0] up_val;
    logic [DATA_W-1:0] rd_val;

    assign ioc_x   = {1'b0, i_ioc};
    assign scr_idx = i_ioc - IOC_W'(8);
    assign is_mv   = (i_ioc == IOC_W'(0));
    assign is_sv   = (i_ioc == IOC_W'(1));
    assign is_mi   = (i_ioc == IOC_W'(2));
    assign is_ctrl = (i_ioc == IOC_W'(3));
    assign is_stat = (i_ioc == IOC_W'(4));
    assign is_scr  = (ioc_x >= SCR_LO) && (ioc_x < SCR_HI);

    assign rd_hit = is_mv | is_sv | is_mi | is_ctrl |
                    is_stat | is_up | is_scr;
    assign wr_hit = is_ctrl | is_stat | is_scr;

    assign fetch_go = i_cs & i_fetch_cmd;
    assign load_go  = i_cs & i_load_cmd;
    assign wr_ctrl  = load_go & is_ctrl;
    assign wr_scr   = load_go & is_scr;
    assign trig     = wr_ctrl & i_data_in[0];
    assign err_clr  = load_go & is_stat & i_data_in[1];
    assign err_set  = (fetch_go & ~rd_hit) | (load_go & ~wr_hit);

    assign busy       = (state_q == S_PULSE);
    assign o_soft_rst = busy;
    assign o_ctrl     = ctrl_q;
    assign o_data_out = dout_q;

`ifdef SYS_CTRL_HEARTBEAT_EN
    logic [HB_DIV_W-1:0] hb_q;

    // Free-running uptime counter; its MSB blinks the heartbeat LED.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_q + 1'b1;
        end
    end

    assign is_up       = (i_ioc == IOC_W'(5));
    assign up_val      = hb_q[HB_DIV_W-1 -: DATA_W];
    assign o_heartbeat = hb_q[HB_DIV_W-1];
`else
    assign is_up       = 1'b0;
    assign up_val      = '0;
    assign o_heartbeat = 1'b0;
`endif

    // Scratch read mux, one-hot over the scratch window.
    always_comb begin
        scr_rd = '0;
        for (int i = 0; i < N_SCRATCH; i++) begin
            if (scr_idx == IOC_W'(i)) begin
                scr_rd = scratch_q[i];
            end
        end
    end

    // Read data for the addressed register; unmapped reads return 0.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            is_mv:   rd_val = DATA_W'(MODULE_VERSION);
            is_sv:   rd_val = DATA_W'(SYSTEM_VERSION);
            is_mi:   rd_val = DATA_W'(MANU_ID);
            is_ctrl: rd_val = {ctrl_q, 1'b0};
            is_stat: rd_val = {{(DATA_W-2){1'b0}}, err_q, busy};
            is_up:   rd_val = up_val;
            is_scr:  rd_val = scr_rd;
            default: rd_val = '0;
        endcase
    end

    // Sticky error: a new error outranks a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Read data, control bits and error flag registers.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            dout_q <= '0;
            ctrl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (fetch_go) begin
                dout_q <= rd_val;
            end
            if (wr_ctrl) begin
                ctrl_q <= i_data_in[DATA_W-1:1];
            end
            err_q <= err_d;
        end
    end

    // Scratch register bank.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (wr_scr) begin
            for (int i = 0; i < N_SCRATCH; i++) begin
                if (scr_idx == IOC_W'(i)) begin
                    scratch_q[i] <= i_data_in;
                end
            end
        end
    end

    // Soft-reset FSM state and remaining-cycle counter.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulse lasts exactly CNT_LOAD clocks; a strobe in PULSE restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_PULSE: begin
                if (trig) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// tb_sys_ctrl_regs: scoreboard bench for sys_ctrl_regs.
// Reads are queued by the driver and popped by a negedge monitor.
module tb_sys_ctrl_regs;

    localparam int DW  = 8;
    localparam int IW  = 5;
    localparam int NS  = 4;
    localparam int SRC = 16;
    localparam int HBW = 10;
`ifdef SYS_CTRL_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] ioc = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          cs = 1'b0;
    logic          fetch = 1'b0;
    logic          load = 1'b0;
    logic          soft_rst;
    logic [DW-2:0] ctrl;
    logic          hb;

    sys_ctrl_regs #(
        .DATA_W(DW), .IOC_W(IW), .N_SCRATCH(NS),
        .SOFT_RST_CYCLES(SRC), .HB_DIV_W(HBW)
    ) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_ioc(ioc),
        .i_data_in(din), .o_data_out(dout), .i_cs(cs),
        .i_fetch_cmd(fetch), .i_load_cmd(load),
        .o_soft_rst(soft_rst), .o_ctrl(ctrl), .o_heartbeat(hb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_ctrl = 0;
    int m_err = 0;
    int m_left = 0;
    int m_hb = 0;
    int m_scr [NS];
    logic [DW-1:0] exp_q [$];
    bit mon_en = 1'b0;

    logic fetch_q = 1'b0;
    logic rst_q = 1'b0;
    logic [DW-1:0] last_exp = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit rd_mapped(input int a);
        return (a <= 4) || (HB && a == 5) || (a >= 8 && a < 8 + NS);
    endfunction

    function automatic int model_read(input int a);
        if (a == 0) return 8'h02;
        if (a == 1) return 8'h01;
        if (a == 2) return 8'h01;
        if (a == 3) return m_ctrl * 2;
        if (a == 4) return m_err * 2 + ((m_left > 0) ? 1 : 0);
        if (a == 5 && HB) return (m_hb >> (HBW - DW)) & 255;
        if (a >= 8 && a < 8 + NS) return m_scr[a-8];
        return 0;
    endfunction

    // Apply one clock edge worth of the register-map rules.
    task automatic model_step(input bit r, input bit c, input bit f,
                              input bit l, input int a, input int d);
        bit seterr;
        bit clr;
        bit trig;
        if (r) begin
            m_ctrl = 0;
            m_err = 0;
            m_left = 0;
            m_hb = 0;
            for (int i = 0; i < NS; i++) m_scr[i] = 0;
            mon_en = 1'b1;
            return;
        end
        seterr = 1'b0;
        clr = 1'b0;
        trig = 1'b0;
        if (c && f) begin
            exp_q.push_back(DW'(model_read(a)));
            if (!rd_mapped(a)) seterr = 1'b1;
        end
        if (c && l) begin
            if (a == 3) begin
                m_ctrl = d / 2;
                trig = d[0];
            end else if (a == 4) begin
                clr = d[1];
            end else if (a >= 8 && a < 8 + NS) begin
                m_scr[a-8] = d;
            end else begin
                seterr = 1'b1;
            end
        end
        if (trig) m_left = SRC;
        else if (m_left > 0) m_left--;
        if (seterr) m_err = 1;
        else if (clr) m_err = 0;
        m_hb = (m_hb + 1) % (1 << HBW);
    endtask

    task automatic drive(input bit r, input bit c, input bit f,
                         input bit l, input int a, input int d);
        rst = r;
        cs = c;
        fetch = f;
        load = l;
        ioc = IW'(a);
        din = DW'(d);
        @(posedge clk);
        model_step(r, c, f, l, a, d & 255);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        drive(0, 1, 1, 0, a, 0);
    endtask

    task automatic wr(input int a, input int d);
        drive(0, 1, 0, 1, a, d);
    endtask

    always @(posedge clk) begin
        fetch_q <= cs & fetch & ~rst;
        rst_q <= rst;
    end

    // Monitor: pop the scoreboard on each read response, check other outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fetch_q) begin
                if (exp_q.size() == 0) begin
                    chk("read_no_expect", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                end
            end else if (rst_q) begin
                last_exp = '0;
            end
            chk("data_out", int'(dout), int'(last_exp));
            chk("soft_rst", int'(soft_rst), (m_left > 0) ? 1 : 0);
            chk("ctrl", int'(ctrl), m_ctrl & 127);
            chk("heartbeat", int'(hb),
                HB ? ((m_hb >> (HBW - 1)) & 1) : 0);
        end
    end

    initial begin
        int a;
        int d;
        bit r;
        for (int i = 0; i < NS; i++) m_scr[i] = 0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        rd(0); rd(1); rd(2); rd(4);

        wr(8, 'hA5); rd(8);
        drive(0, 0, 0, 1, 8, 'h5A);
        drive(0, 0, 1, 0, 9, 0);
        rd(8);

        wr(3, 'h07); rd(4); rd(3);
        idle(20);
        rd(4);

        wr(3, 'h01); idle(9); wr(3, 'h01); idle(30);

        wr(3, 'h01); idle(4); drive(1, 0, 0, 0, 0, 0); idle(3);

        wr(0, 'hFF); rd(31); rd(4);
        wr(4, 'h02); rd(4);
        rd(31); wr(4, 'h01); rd(4);
        drive(0, 1, 1, 1, 4, 'h02); rd(4);
        drive(0, 1, 1, 1, 12, 'h33); rd(4);

        rd(5); rd(4);
        wr(5, 'h11); rd(5); rd(4);
        wr(4, 'h02);

        for (int n = 0; n < 2500; n++) begin
            a = ($urandom_range(0, 9) == 0) ?
                int'($urandom_range(12, 31)) : int'($urandom_range(0, 11));
            d = int'($urandom_range(0, 255));
            r = ($urandom_range(0, 299) == 0);
            if (r) drive(1, 0, 0, 0, 0, 0);
            else drive(0, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 2) == 0, a, d);
        end

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
